// File: rtl/am_lock_lane_fsm.sv
// Per-lane alignment-marker lock: finds the PCS lane in the stream, confirms it one AM period later, then tracks it.
// Latency: 1 cycle from an accepted block to registered outputs (async reset clears outputs at once).
// Backpressure: none; i_valid=0 freezes timer/FSM state and suppresses pulses. Optional AM_LOCK_ERRCNT_EN adds o_err_count.
module am_lock_lane_fsm #(
  parameter  int NB_BLOCK  = 66,
  parameter  int NB_AM     = 48,
  parameter  int N_ALIGNER = 20,
  parameter  int AM_PERIOD = 16384,
  parameter  int N_INVALID = 4,
  localparam int NB_ID     = (N_ALIGNER > 1) ? $clog2(N_ALIGNER) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_valid,
  input  logic                i_block_lock,
  input  logic [NB_BLOCK-1:0] i_data,
  input  logic [NB_AM-1:0]    i_compare_mask,
  output logic                o_am_lock,
  output logic [NB_ID-1:0]    o_lane_id,
  output logic                o_am_flag,
  output logic                o_am_match
`ifdef AM_LOCK_ERRCNT_EN
  ,
  output logic [15:0]         o_err_count
`endif
);

  localparam int TW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam int CW = $clog2(N_INVALID + 1);

  typedef enum logic [1:0] {LOCK_INIT, GET_AM, COMP_AM, CHECK} state_t;

  // Standard 100G marker bytes {M0,M1,M2}; M4..M6 are their bitwise complement.
  function automatic logic [23:0] am_head(input int k);
    case (k)
      0:       am_head = 24'hC16821;
      1:       am_head = 24'h9D718E;
      2:       am_head = 24'h594BE8;
      3:       am_head = 24'h4D957B;
      4:       am_head = 24'hF50709;
      5:       am_head = 24'hDD14C2;
      6:       am_head = 24'h9A4A26;
      7:       am_head = 24'h7B4566;
      8:       am_head = 24'hA02476;
      9:       am_head = 24'h68C9FB;
      10:      am_head = 24'hFD6C99;
      11:      am_head = 24'hB99155;
      12:      am_head = 24'h5CB9B2;
      13:      am_head = 24'h1AF8BD;
      14:      am_head = 24'h83C7CA;
      15:      am_head = 24'h3536CD;
      16:      am_head = 24'hC4314C;
      17:      am_head = 24'hADD6B7;
      18:      am_head = 24'h5F662A;
      19:      am_head = 24'hC0F0E5;
      default: am_head = 24'h000000;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    invld_q, invld_d;
  logic             lock_d, flag_d, match_d;
  logic [NB_ID-1:0] id_d;

  logic [1:0]           sh;
  logic [NB_AM-1:0]     am_rx;
  logic [N_ALIGNER-1:0] match_vec;
  logic                 any_hit;
  logic [NB_ID-1:0]     hit_id;
  logic                 lane_hit;
  logic                 at_am;
  logic                 unused_bip;

  // BIP3/BIP7 carry parity, never part of the marker compare.
  assign sh         = i_data[NB_BLOCK-1 -: 2];
  assign am_rx      = {i_data[63:40], i_data[31:8]};
  assign unused_bip = ^{i_data[39:32], i_data[7:0]};
  assign any_hit    = |match_vec;
  assign at_am      = (timer_q == TW'(AM_PERIOD - 1));

  // Masked compare of the block against every lane's marker.
  always_comb begin
    match_vec = '0;
    for (int k = 0; k < N_ALIGNER; k++) begin
      match_vec[k] = (sh == 2'b10) &&
                     (&(~(am_rx ^ {am_head(k), ~am_head(k)}) | ~i_compare_mask));
    end
  end

  // Lowest matching lane for capture, and whether the captured lane matches.
  always_comb begin
    hit_id   = '0;
    lane_hit = 1'b0;
    for (int k = N_ALIGNER - 1; k >= 0; k--) begin
      if (match_vec[k]) hit_id = NB_ID'(k);
    end
    for (int k = 0; k < N_ALIGNER; k++) begin
      if (NB_ID'(k) == o_lane_id) lane_hit = match_vec[k];
    end
  end

  // Lock FSM next state, timer, invalid counter and output values.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    invld_d = invld_q;
    lock_d  = o_am_lock;
    id_d    = o_lane_id;
    flag_d  = 1'b0;
    match_d = 1'b0;
    if (!i_block_lock) begin
      state_d = LOCK_INIT;
      timer_d = '0;
      invld_d = '0;
      lock_d  = 1'b0;
      id_d    = '0;
    end else begin
      case (state_q)
        LOCK_INIT: begin
          timer_d = '0;
          invld_d = '0;
          lock_d  = 1'b0;
          state_d = GET_AM;
        end
        GET_AM: begin
          if (i_valid && any_hit) begin
            id_d    = hit_id;
            timer_d = '0;
            state_d = COMP_AM;
          end
        end
        COMP_AM: begin
          if (i_valid) begin
            if (at_am) begin
              timer_d = '0;
              if (lane_hit) begin
                state_d = CHECK;
                lock_d  = 1'b1;
                invld_d = '0;
              end else begin
                state_d = GET_AM;
              end
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (i_valid) begin
            if (at_am) begin
              timer_d = '0;
              flag_d  = 1'b1;
              if (lane_hit) begin
                match_d = 1'b1;
                invld_d = '0;
              end else if (invld_q == CW'(N_INVALID - 1)) begin
                state_d = LOCK_INIT;
                lock_d  = 1'b0;
                invld_d = '0;
              end else begin
                invld_d = invld_q + 1'b1;
              end
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        default: state_d = LOCK_INIT;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= LOCK_INIT;
      timer_q    <= '0;
      invld_q    <= '0;
      o_am_lock  <= 1'b0;
      o_lane_id  <= '0;
      o_am_flag  <= 1'b0;
      o_am_match <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      invld_q    <= invld_d;
      o_am_lock  <= lock_d;
      o_lane_id  <= id_d;
      o_am_flag  <= flag_d;
      o_am_match <= match_d;
    end
  end

`ifdef AM_LOCK_ERRCNT_EN
  logic bad_am;

  // A missed marker at an expected position, either while confirming or while locked.
  assign bad_am = i_block_lock && i_valid && at_am && !lane_hit &&
                  ((state_q == COMP_AM) || (state_q == CHECK));

  // Saturating bad-marker counter, cleared only by reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_count <= 16'h0000;
    end else if (bad_am && (o_err_count != 16'hFFFF)) begin
      o_err_count <= o_err_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_am_lock_lane_fsm.sv
// Bench for am_lock_lane_fsm: directed block streams with per-cycle expected outputs queued by stimulus.
// A monitor pops one expectation after every clock that follows a driven cycle and compares.
// A second instance at the full 16384-block period checks one lock acquisition.
module tb_am_lock_lane_fsm;
  localparam int P      = 16;
  localparam int P_LONG = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        blk = 1'b1;
  logic [65:0] data = '0;
  logic [47:0] mask = '1;
  logic        lock, flag, match;
  logic [4:0]  id;

  logic        valid2 = 1'b0;
  logic        blk2 = 1'b1;
  logic [65:0] data2 = '0;
  logic        lock2, flag2, match2;
  logic [4:0]  id2;

`ifdef AM_LOCK_ERRCNT_EN
  logic [15:0] errc, errc2;
`endif

  always #5 clk = ~clk;

  am_lock_lane_fsm #(.AM_PERIOD(P)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .i_block_lock(blk),
    .i_data(data), .i_compare_mask(mask),
    .o_am_lock(lock), .o_lane_id(id), .o_am_flag(flag), .o_am_match(match)
`ifdef AM_LOCK_ERRCNT_EN
    , .o_err_count(errc)
`endif
  );

  am_lock_lane_fsm #(.AM_PERIOD(P_LONG)) dut_long (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid2), .i_block_lock(blk2),
    .i_data(data2), .i_compare_mask(48'hFFFF_FFFF_FFFF),
    .o_am_lock(lock2), .o_lane_id(id2), .o_am_flag(flag2), .o_am_match(match2)
`ifdef AM_LOCK_ERRCNT_EN
    , .o_err_count(errc2)
`endif
  );

  typedef struct packed {
    logic       lock;
    logic [4:0] id;
    logic       flag;
    logic       match;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic rst_lvl = 1'b0;
  logic blk_lvl = 1'b1;

  function automatic logic [65:0] am_blk(input int k);
    logic [23:0] m;
    case (k)
      0:       m = 24'hC16821;
      3:       m = 24'h4D957B;
      5:       m = 24'hDD14C2;
      6:       m = 24'h9A4A26;
      9:       m = 24'h68C9FB;
      default: m = 24'h000000;
    endcase
    return {2'b10, m, 8'hA5, ~m, 8'h3C};
  endfunction

  function automatic logic [65:0] dat_blk(input int i);
    logic [31:0] x;
    x = i * 32'h9E3779B9 + 32'h1234_5678;
    return {2'b01, x, ~x};
  endfunction

  task automatic push_cyc(input logic v, input logic [65:0] d, input logic lk,
                          input logic [4:0] li, input logic fl, input logic mt);
    @(negedge clk);
    rst_n = rst_lvl;
    blk   = blk_lvl;
    valid = v;
    data  = d;
    exp_q.push_back({lk, li, fl, mt});
  endtask

  task automatic send(input logic [65:0] d, input logic lk, input logic [4:0] li,
                      input logic fl, input logic mt);
    push_cyc(1'b1, d, lk, li, fl, mt);
  endtask

  task automatic idle(input logic lk, input logic [4:0] li);
    push_cyc(1'b0, am_blk(5), lk, li, 1'b0, 1'b0);
  endtask

  task automatic run_data(input int n, input logic lk, input logic [4:0] li);
    for (int i = 0; i < n; i++) send(dat_blk(i), lk, li, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the capturing edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {lock, id, flag, match};
        total++;
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL cyc%0d outputs lock/id/flag/match: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                   cyc, mon_a.lock, mon_a.id, mon_a.flag, mon_a.match,
                   mon_e.lock, mon_e.id, mon_e.flag, mon_e.match);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [65:0] b;

    // Reset, release, LOCK_INIT -> GET_AM.
    idle(0, 0); idle(0, 0);
    rst_lvl = 1'b1;
    idle(0, 0); idle(0, 0);

    // Lane 5 acquisition and confirmation.
    send(am_blk(5), 0, 5, 0, 0);
    run_data(P - 1, 0, 5);
    send(am_blk(5), 1, 5, 0, 0);
    run_data(P - 1, 1, 5);
    send(am_blk(5), 1, 5, 1, 1);

    // Three bad markers of different kinds keep lock.
    run_data(P - 1, 1, 5);
    send(am_blk(6), 1, 5, 1, 0);
    run_data(P - 1, 1, 5);
    b = am_blk(5); b[60] = ~b[60];
    send(b, 1, 5, 1, 0);
    run_data(P - 1, 1, 5);
    b = am_blk(5); b[65:64] = 2'b01;
    send(b, 1, 5, 1, 0);

    // Good marker with corrupted M0 hidden by the mask clears the count.
    run_data(P - 1, 1, 5);
    mask = 48'h00FF_FFFF_FFFF;
    b = am_blk(5); b[63:56] = 8'h00;
    send(b, 1, 5, 1, 1);
    @(posedge clk); #1;
    mask = '1;

    // Four consecutive bad markers drop lock on the fourth.
    for (int r = 0; r < 3; r++) begin
      run_data(P - 1, 1, 5);
      send(am_blk(6), 1, 5, 1, 0);
    end
    run_data(P - 1, 1, 5);
    send(am_blk(6), 0, 5, 1, 0);
    idle(0, 5);

    // Failed confirm on a lane-6 marker, that block not re-captured, relock on lane 5.
    send(am_blk(5), 0, 5, 0, 0);
    run_data(P - 1, 0, 5);
    send(am_blk(6), 0, 5, 0, 0);
    send(am_blk(5), 0, 5, 0, 0);
    run_data(P - 1, 0, 5);
    send(am_blk(5), 1, 5, 0, 0);

    // Locked with random idle gaps; idle cycles carry marker data that must be ignored.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < P; i++) begin
        repeat ($urandom_range(0, 7)) idle(1, 5);
        if (i < P - 1) send(dat_blk(i), 1, 5, 0, 0);
        else           send(am_blk(5), 1, 5, 1, 1);
      end
    end

    // Block lock loss overrides everything.
    blk_lvl = 1'b0;
    send(dat_blk(3), 0, 0, 0, 0);
    blk_lvl = 1'b1;
    idle(0, 0);

    // Asynchronous reset in COMP_AM clears outputs without a clock edge.
    send(am_blk(5), 0, 5, 0, 0);
    run_data(5, 0, 5);
    @(negedge clk);
    rst_lvl = 1'b0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    #1;
    total++;
    if ({lock, id, flag, match} !== 8'h00) begin
      bad++;
      $display("FAIL async_reset outputs: got %b/%0d/%b/%b want 0/0/0/0", lock, id, flag, match);
    end
    idle(0, 0); idle(0, 0);
    rst_lvl = 1'b1;
    idle(0, 0); idle(0, 0);

    // All-zero mask captures the lowest lane; confirmed by lane 0 marker one period later.
    mask = '0;
    send(am_blk(9), 0, 0, 0, 0);
    @(posedge clk); #1;
    mask = '1;
    run_data(P - 1, 0, 0);
    send(am_blk(0), 1, 0, 0, 0);
    run_data(P - 1, 1, 0);
    send(am_blk(0), 1, 0, 1, 1);
    idle(1, 0); idle(1, 0);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end

    // Full-length period on the second instance.
    @(negedge clk);
    valid2 = 1'b1;
    data2  = am_blk(3);
    for (int i = 0; i < P_LONG - 1; i++) begin
      @(negedge clk);
      data2 = dat_blk(i);
    end
    @(negedge clk);
    total++;
    if (lock2 !== 1'b0 || id2 !== 5'd3) begin
      bad++;
      $display("FAIL long_before_am lock/id: got %b/%0d want 0/3", lock2, id2);
    end
    data2 = am_blk(3);
    @(negedge clk);
    valid2 = 1'b0;
    total++;
    if (lock2 !== 1'b1 || id2 !== 5'd3 || flag2 !== 1'b0 || match2 !== 1'b0) begin
      bad++;
      $display("FAIL long_lock lock/id/flag/match: got %b/%0d/%b/%b want 1/3/0/0",
               lock2, id2, flag2, match2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
